popcount_frame_acc: RTL and testbench

Downstream consumer of the 16-bit popcount stage. Takes one 5-bit ones-count per input word over a valid/ready stream and accumulates counts across a frame. A frame closes after FRAME_LEN words or on an early `in_last`. Each frame's total, word count, threshold flag and error flag are presented on a single-entry registered valid/ready output.

---
 rtl/popcount_frame_acc.sv | 124 ++++++++++++
 tb/tb_popcount_frame_acc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/popcount_frame_acc.sv
// rtl/popcount_frame_acc.sv - accumulates per-word ones counts into framed totals
//
// Parameters:
//   FRAME_LEN  words per full frame (1..255)
//   SUM_W      accumulator / out_sum width, saturating at all-ones
//   THRESH     out_over asserts when the frame sum >= THRESH
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready             input word handshake
//   in_count[4:0], in_last        ones count of one word, early frame close
//   out_valid/out_ready           single-entry registered result handshake
//   out_sum, out_words            frame total and number of words in it
//   out_over, out_err, out_sat    threshold, bad-count and saturation flags
//   frames[7:0]                   results handed off, wrapping
module popcount_frame_acc #(
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 8,
  parameter int THRESH    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_count,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [7:0]       out_words,
  output logic             out_over,
  output logic             out_err,
  output logic             out_sat,
  output logic [7:0]       frames
);

  logic [SUM_W-1:0] acc;
  logic [7:0]       word_cnt;
  logic             err;
  logic             sat;

  logic             accept;
  logic             handoff;
  logic             closing;
  logic             bad_count;
  logic [4:0]       eff_count;
  logic [SUM_W:0]   sum_wide;
  logic             sat_hit;
  logic [SUM_W-1:0] acc_nxt;
  logic [7:0]       cnt_nxt;
  logic             err_nxt;
  logic             sat_nxt;
  logic             over_nxt;

  // The output slot is free when empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;

  always_comb begin
    bad_count = 1'b0;
    eff_count = in_count;
    if (in_count > 5'd16) begin
      bad_count = 1'b1;
      eff_count = 5'd16;
    end
  end

  // One extra bit catches the carry that signals saturation.
  assign sum_wide = {1'b0, acc} + (SUM_W+1)'(eff_count);
  assign sat_hit  = sum_wide[SUM_W];
  assign acc_nxt  = sat_hit ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
  assign cnt_nxt  = word_cnt + 8'd1;
  assign err_nxt  = err || bad_count;
  assign sat_nxt  = sat || sat_hit;
  assign over_nxt = 32'(acc_nxt) >= 32'(THRESH);

  // in_last on the FRAME_LEN-th word still closes only one frame.
  assign closing = accept && (in_last || (word_cnt == 8'(FRAME_LEN - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      word_cnt  <= 8'd0;
      err       <= 1'b0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_words <= 8'd0;
      out_over  <= 1'b0;
      out_err   <= 1'b0;
      out_sat   <= 1'b0;
      frames    <= 8'd0;
    end else begin
      if (handoff) begin
        frames <= frames + 8'd1;
      end

      if (closing) begin
        out_valid <= 1'b1;
        out_sum   <= acc_nxt;
        out_words <= cnt_nxt;
        out_over  <= over_nxt;
        out_err   <= err_nxt;
        out_sat   <= sat_nxt;
        acc       <= '0;
        word_cnt  <= 8'd0;
        err       <= 1'b0;
        sat       <= 1'b0;
      end else begin
        // Result fields stay put after a handoff; only valid drops.
        if (handoff) begin
          out_valid <= 1'b0;
        end
        if (accept) begin
          acc      <= acc_nxt;
          word_cnt <= cnt_nxt;
          err      <= err_nxt;
          sat      <= sat_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_popcount_frame_acc.sv
// tb/tb_popcount_frame_acc.sv - directed table and sequence checks for popcount_frame_acc
module tb_popcount_frame_acc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_count = 5'd0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic [7:0] out_words;
  logic       out_over;
  logic       out_err;
  logic       out_sat;
  logic [7:0] frames;

  logic       s_in_valid = 1'b0;
  logic       s_in_ready;
  logic [4:0] s_in_count = 5'd0;
  logic       s_in_last = 1'b0;
  logic       s_out_valid;
  logic       s_out_ready = 1'b0;
  logic [5:0] s_out_sum;
  logic [7:0] s_out_words;
  logic       s_out_over;
  logic       s_out_err;
  logic       s_out_sat;
  logic [7:0] s_frames;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  popcount_frame_acc dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_words(out_words),
    .out_over(out_over), .out_err(out_err), .out_sat(out_sat), .frames(frames)
  );

  popcount_frame_acc #(.SUM_W(6)) dut6 (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_count(s_in_count), .in_last(s_in_last),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum), .out_words(s_out_words),
    .out_over(s_out_over), .out_err(s_out_err), .out_sat(s_out_sat), .frames(s_frames)
  );

  typedef struct {
    logic       v;
    logic [4:0] cnt;
    logic       last;
    logic       ordy;
    logic       e_valid;
    logic [7:0] e_sum;
    logic [7:0] e_words;
    logic       e_over;
    logic       e_err;
    logic       e_sat;
    logic [7:0] e_frames;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [4:0] cnt, input logic last, input logic ordy,
                     input logic ev, input logic [7:0] es, input logic [7:0] ew,
                     input logic eo, input logic ee, input logic esat, input logic [7:0] ef);
    vec_t r;
    r.v = v; r.cnt = cnt; r.last = last; r.ordy = ordy;
    r.e_valid = ev; r.e_sum = es; r.e_words = ew;
    r.e_over = eo; r.e_err = ee; r.e_sat = esat; r.e_frames = ef;
    tbl.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [4:0] cnt, input logic last, input logic ordy);
    in_valid = v; in_count = cnt; in_last = last; out_ready = ordy;
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [7:0] es,
                           input logic [7:0] ew, input logic eo, input logic ee,
                           input logic esat, input logic [7:0] ef);
    check({tag, ".valid"}, 32'(out_valid), 32'(ev));
    check({tag, ".sum"},   32'(out_sum),   32'(es));
    check({tag, ".words"}, 32'(out_words), 32'(ew));
    check({tag, ".over"},  32'(out_over),  32'(eo));
    check({tag, ".err"},   32'(out_err),   32'(ee));
    check({tag, ".sat"},   32'(out_sat),   32'(esat));
    check({tag, ".frames"}, 32'(frames),   32'(ef));
  endtask

  initial begin
    // Full frame of 16s
    for (int i = 0; i < 7; i++) add(1, 16, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 16, 0, 1, 1, 128, 8, 1, 0, 0, 0);
    // Early close 5,0,7; first word drains the previous result
    add(1, 5, 0, 1, 0, 128, 8, 1, 0, 0, 1);
    add(1, 0, 0, 1, 0, 128, 8, 1, 0, 0, 1);
    add(1, 7, 1, 1, 1, 12, 3, 0, 0, 0, 1);
    // Clamp: 20 then seven 1s
    add(1, 20, 0, 1, 0, 12, 3, 0, 0, 0, 2);
    for (int i = 0; i < 6; i++) add(1, 1, 0, 1, 0, 12, 3, 0, 0, 0, 2);
    add(1, 1, 0, 1, 1, 23, 8, 0, 1, 0, 2);
    // Back-to-back single-word frames: no bubble
    add(1, 9, 1, 1, 1, 9, 1, 0, 0, 0, 3);
    add(1, 16, 1, 1, 1, 16, 1, 0, 0, 0, 4);
    // in_last on the eighth word closes exactly one frame
    for (int i = 0; i < 7; i++) add(1, 10, 0, 1, 0, 16, 1, 0, 0, 0, 5);
    add(1, 10, 1, 1, 1, 80, 8, 1, 0, 0, 5);
    // Idle with a held result, then drain
    add(0, 0, 0, 0, 1, 80, 8, 1, 0, 0, 5);
    add(0, 0, 0, 1, 0, 80, 8, 1, 0, 0, 6);
    // Idle mid-frame with garbage on the bus is ignored
    add(1, 4, 0, 1, 0, 80, 8, 1, 0, 0, 6);
    add(0, 31, 1, 1, 0, 80, 8, 1, 0, 0, 6);
    add(1, 4, 1, 1, 1, 8, 2, 0, 0, 0, 6);

    // Reset state
    #12;
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check_out("rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].cnt, tbl[i].last, tbl[i].ordy);
      step();
      check_out($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_sum, tbl[i].e_words,
                tbl[i].e_over, tbl[i].e_err, tbl[i].e_sat, tbl[i].e_frames);
    end

    // Backpressure: frame of 2s, stall 10 cycles, release
    for (int i = 0; i < 8; i++) begin
      drive(1, 2, 0, 1);
      step();
    end
    check_out("bp.close", 1, 16, 8, 0, 0, 0, 7);
    for (int i = 0; i < 10; i++) begin
      drive(1, 3, 0, 0);
      #1;
      check($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'd0);
      step();
      check_out($sformatf("bp.hold%0d", i), 1, 16, 8, 0, 0, 0, 7);
    end
    drive(1, 3, 0, 1);
    #1;
    check("bp.in_ready_rel", 32'(in_ready), 32'd1);
    step();
    check_out("bp.release", 0, 16, 8, 0, 0, 0, 8);
    for (int i = 0; i < 7; i++) begin
      drive(1, 3, 0, 1);
      step();
    end
    check_out("bp.resume", 1, 24, 8, 0, 0, 0, 8);

    // Reset mid-frame
    for (int i = 0; i < 4; i++) begin
      drive(1, 3, 0, 1);
      step();
    end
    check("mid.frames", 32'(frames), 32'd9);
    drive(0, 0, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    check_out("mid.rst", 0, 0, 0, 0, 0, 0, 0);
    check("mid.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 1);
      step();
    end
    check_out("mid.after", 1, 8, 8, 0, 0, 0, 0);
    drive(0, 0, 0, 1);
    step();

    // Saturation on the SUM_W=6 instance
    for (int i = 0; i < 8; i++) begin
      s_in_valid = 1'b1; s_in_count = 5'd16; s_in_last = 1'b0; s_out_ready = 1'b0;
      step();
    end
    s_in_valid = 1'b0;
    check("sat.valid", 32'(s_out_valid), 32'd1);
    check("sat.sum",   32'(s_out_sum),   32'd63);
    check("sat.words", 32'(s_out_words), 32'd8);
    check("sat.sat",   32'(s_out_sat),   32'd1);
    check("sat.over",  32'(s_out_over),  32'd0);
    check("sat.err",   32'(s_out_err),   32'd0);
    check("sat.in_ready", 32'(s_in_ready), 32'd0);
    s_out_ready = 1'b1;
    step();
    check("sat.frames", 32'(s_frames), 32'd1);
    check("sat.drain",  32'(s_out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
